// File: rtl/rr_handshake_arbiter_pkg.sv
// Shared definitions for the round-robin handshake arbiter.
//   rr_state_t : arbiter FSM state (idle search / locked on a stalled offer).
//   rr_inc     : circular increment of a requester index modulo n.
package rr_handshake_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } rr_state_t;

  // Next index after idx, wrapping to 0 at n.
  function automatic int unsigned rr_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_handshake_arbiter_picker.sv
// Circular find-first-set: returns the first asserted request at or after prio_i,
// wrapping modulo N_REQ.
//   req_i       : request vector
//   prio_i      : index with highest priority
//   grant_idx_o : selected index (prio_i when nothing is requested)
//   any_valid_o : at least one request asserted
module rr_priority_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] prio_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_valid_o
);

  always_comb begin
    int         k;
    logic [IDX_W-1:0] k_idx;
    grant_idx_o = prio_i;
    any_valid_o = 1'b0;
    k           = 0;
    k_idx       = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      k     = (int'(prio_i) + i) % int'(N_REQ);
      k_idx = IDX_W'(k);
      if (!any_valid_o && req_i[k_idx]) begin
        grant_idx_o = k_idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among N_REQ requesters.
// The grant is locked while an offer is stalled so valid/data stay stable until
// accepted. Forward path is combinational; intended to feed a flushable spill cell.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   flush_i        : synchronous flush (drops lock, priority back to 0)
//   valid_i/data_i : per-requester offers, ready_o : per-requester accept (one-hot or 0)
//   valid_o/data_o : downstream offer, ready_i : downstream accept
//   grant_idx_o    : currently granted requester
module rr_handshake_arbiter
  import rr_handshake_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter type         DATA_T = logic,
  parameter int unsigned IDX_W  = $clog2(N_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic  [N_REQ-1:0]        valid_i,
  output logic  [N_REQ-1:0]        ready_o,
  input  DATA_T [N_REQ-1:0]        data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output DATA_T                    data_o,
  output logic  [IDX_W-1:0]        grant_idx_o
);

  rr_state_t        state_q, state_d;
  logic [IDX_W-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [IDX_W-1:0] sel_idx;
  logic             any_valid;
  logic             handshake;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i       (valid_i),
    .prio_i      (prio_q),
    .grant_idx_o (sel_idx),
    .any_valid_o (any_valid)
  );

  // Outputs. valid_o depends only on valid_i/state/flush, never on ready_i.
  always_comb begin
    if (state_q == StLocked) begin
      grant_idx_o = lock_idx_q;
      valid_o     = valid_i[lock_idx_q] & ~flush_i;
    end else begin
      grant_idx_o = sel_idx;
      valid_o     = any_valid & ~flush_i;
    end
    data_o    = data_i[grant_idx_o];
    handshake = valid_o & ready_i;
    ready_o   = '0;
    if (handshake) begin
      ready_o[grant_idx_o] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      state_d = StIdle;
      prio_d  = '0;
    end else if (handshake) begin
      state_d = StIdle;
      prio_d  = IDX_W'(rr_inc(32'(grant_idx_o), N_REQ));
    end else if (state_q == StIdle && valid_o) begin
      state_d    = StLocked;
      lock_idx_d = grant_idx_o;
    end
    // A locked requester that drops valid keeps the lock until it completes or flush.
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      prio_q     <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  ready_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    $onehot0(ready_o));

  // Upstream must hold valid on the locked requester until it is accepted.
  lock_valid_held_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == StLocked && !flush_i) |-> valid_i[lock_idx_q]);

  grant_stable_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (valid_o && !ready_i) |=> (flush_i || grant_idx_o == $past(grant_idx_o)));

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
module tb_rr_handshake_arbiter;
  import rr_handshake_arbiter_pkg::*;

  localparam int unsigned N = 4;
  typedef logic [7:0] data_t;
  typedef data_t q_t [$];

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              flush_i = 1'b0;
  logic  [N-1:0]     valid_i = '0;
  logic  [N-1:0]     ready_o;
  data_t [N-1:0]     data_i = '0;
  logic              valid_o;
  logic              ready_i = 1'b0;
  data_t             data_o;
  logic  [1:0]       grant_idx_o;

  int n_total = 0;
  int n_pass  = 0;

  q_t   exp_q [N];
  int   wait_cnt [N];
  logic [5:0] seq [N];
  logic [N-1:0] accepted;

  always #5 clk_i = ~clk_i;

  rr_handshake_arbiter #(
    .N_REQ  (N),
    .DATA_T (data_t)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .grant_idx_o (grant_idx_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    valid_i = '0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  initial begin
    logic [N-1:0] onehot;
    int g;
    int guard;
    data_i = {8'h33, 8'h22, 8'h11, 8'h5C};
    do_reset();

    // Reset state with no requests.
    @(negedge clk_i);
    check("rst_valid_o", 32'(valid_o), 0);
    check("rst_ready_o", 32'(ready_o), 0);
    check("rst_grant", 32'(grant_idx_o), 0);
    check("rst_data_o", 32'(data_o), 32'h5C);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    next_cycle();

    // 1: all valid, downstream always ready -> 0,1,2,3,0.
    valid_i = 4'hF;
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int e;
      e = i % 4;
      onehot = 4'b0001 << e;
      @(negedge clk_i);
      check("rr_grant", 32'(grant_idx_o), 32'(e));
      check("rr_ready", 32'(ready_o), 32'(onehot));
      check("rr_data", 32'(data_o), 32'(data_i[e]));
      next_cycle();
    end

    // 2: stall on req 2, req 0 arrives late, then drain.
    do_reset();
    data_i[2] = 8'hA5;
    valid_i   = 4'b0100;
    ready_i   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) valid_i[0] = 1'b1;
      @(negedge clk_i);
      check("stall_valid", 32'(valid_o), 1);
      check("stall_data", 32'(data_o), 32'hA5);
      check("stall_grant", 32'(grant_idx_o), 2);
      check("stall_ready", 32'(ready_o), 0);
      next_cycle();
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    check("stall_xfer", 32'(ready_o), 32'b0100);
    next_cycle();
    valid_i[2] = 1'b0;
    @(negedge clk_i);
    check("stall_prio", 32'(dut.prio_q), 3);
    check("stall_next_grant", 32'(grant_idx_o), 0);
    check("stall_next_ready", 32'(ready_o), 32'b0001);
    next_cycle();

    // 3: flush while locked on req 1 with ready_i high.
    do_reset();
    valid_i = 4'b0010;
    ready_i = 1'b0;
    next_cycle();
    check("flush_locked", 32'(dut.state_q), 32'(StLocked));
    valid_i = 4'b0011;
    ready_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_ready", 32'(ready_o), 0);
    check("flush_valid", 32'(valid_o), 0);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_state", 32'(dut.state_q), 32'(StIdle));
    check("flush_prio", 32'(dut.prio_q), 0);
    check("flush_grant", 32'(grant_idx_o), 0);
    check("flush_first_ready", 32'(ready_o), 32'b0001);
    next_cycle();

    // 4: single requester gets every cycle.
    do_reset();
    valid_i = 4'b1000;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("single_grant", 32'(grant_idx_o), 3);
      check("single_ready", 32'(ready_o), 32'b1000);
      next_cycle();
    end

    // 5: asynchronous reset in the middle of a lock on req 2.
    do_reset();
    valid_i = 4'b0100;
    ready_i = 1'b0;
    next_cycle();
    check("arst_locked", 32'(dut.state_q), 32'(StLocked));
    #2;
    rst_n_i = 1'b0;
    valid_i = '0;
    ready_i = 1'b1;
    #1;
    check("arst_valid", 32'(valid_o), 0);
    check("arst_ready", 32'(ready_o), 0);
    check("arst_state", 32'(dut.state_q), 32'(StIdle));
    next_cycle();
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("arst_prio", 32'(dut.prio_q), 0);
    check("arst_state_rel", 32'(dut.state_q), 32'(StIdle));
    next_cycle();

    // 6: random traffic against per-requester scoreboard queues.
    do_reset();
    for (int k = 0; k < N; k++) begin
      wait_cnt[k] = 0;
      seq[k]      = '0;
    end
    accepted = '0;
    for (int cyc = 0; cyc < 10200; cyc++) begin
      logic gen;
      gen = (cyc < 10000);
      for (int k = 0; k < N; k++) begin
        if (accepted[k]) valid_i[k] = 1'b0;
        if (!valid_i[k] && gen && $urandom_range(1, 0) == 1) begin
          data_i[k]  = {2'(k), seq[k]};
          seq[k]     = seq[k] + 6'd1;
          valid_i[k] = 1'b1;
          exp_q[k].push_back(data_i[k]);
        end
      end
      ready_i  = gen ? ($urandom_range(3, 0) != 0) : 1'b1;
      flush_i  = gen && ($urandom_range(31, 0) == 0);
      accepted = '0;
      @(negedge clk_i);
      check("rnd_onehot", 32'($onehot0(ready_o)), 1);
      if (flush_i) begin
        check("rnd_flush_valid", 32'(valid_o), 0);
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
      end else if (valid_o && ready_i) begin
        g = int'(grant_idx_o);
        onehot = 4'b0001 << g;
        check("rnd_ready", 32'(ready_o), 32'(onehot));
        if (exp_q[g].size() == 0) begin
          check("rnd_spurious", 32'(g), 32'hFFFF);
        end else begin
          check("rnd_data", 32'(data_o), 32'(exp_q[g].pop_front()));
        end
        check("rnd_starve", 32'(wait_cnt[g] < int'(N)), 1);
        wait_cnt[g] = 0;
        for (int k = 0; k < N; k++) if (k != g && valid_i[k]) wait_cnt[k]++;
        accepted[g] = 1'b1;
      end else begin
        check("rnd_no_xfer", 32'(ready_o), 0);
      end
      next_cycle();
    end
    for (int k = 0; k < N; k++) if (accepted[k]) valid_i[k] = 1'b0;
    guard = 0;
    for (int k = 0; k < N; k++) begin
      check("rnd_drained", 32'(exp_q[k].size()), 0);
      guard += exp_q[k].size();
    end
    ready_i = 1'b0;
    valid_i = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
